// File: rtl/drizzle_allocator.sv
// drizzle_allocator: round-robin N-input output-port allocator with packet locking and a 1-entry output stage.
// Optional stall statistic enabled by defining DRIZZLE_ALLOC_STATS_EN.
module drizzle_allocator #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned DATA_W = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN-1:0]        tail,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  output logic [NUM_IN-1:0]        ready,
  input  logic                     out_FIFO_full,
  output logic                     out_FIFO_wr,
  output logic [DATA_W-1:0]        data_out,
  output logic [15:0]              stall_count
);

  localparam int unsigned PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   lock_id;
  logic               stage_valid;
  logic [DATA_W-1:0]  stage_data;

  logic [PTR_W-1:0]   grant_id;
  logic               grant_found;
  logic [PTR_W-1:0]   next_ptr;
  logic               stage_free;
  logic               xfer;
  logic               xfer_tail;
  logic [DATA_W-1:0]  grant_data;
  int unsigned        idx;

  // Grant selection: locked input only, otherwise first requester from rr_ptr upward.
  always_comb begin
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    if (state == LOCKED) begin
      grant_id    = lock_id;
      grant_found = req[lock_id];
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (!grant_found && req[PTR_W'(idx)]) begin
          grant_id    = PTR_W'(idx);
          grant_found = 1'b1;
        end
      end
    end
  end

  assign out_FIFO_wr = stage_valid & ~out_FIFO_full;
  assign data_out    = stage_data;
  assign stage_free  = ~stage_valid | out_FIFO_wr;
  assign xfer        = grant_found & stage_free;
  assign xfer_tail   = tail[grant_id];
  assign grant_data  = data_in[32'(grant_id)*DATA_W +: DATA_W];
  assign next_ptr    = (32'(grant_id) == NUM_IN - 1) ? '0 : grant_id + PTR_W'(1);

  always_comb begin
    ready = '0;
    if (xfer) ready[grant_id] = 1'b1;
  end

  // Arbitration state and output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_id     <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      if (xfer) begin
        stage_data  <= grant_data;
        stage_valid <= 1'b1;
      end else if (out_FIFO_wr) begin
        stage_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (xfer) begin
            if (xfer_tail) begin
              rr_ptr <= next_ptr;
            end else begin
              state   <= LOCKED;
              lock_id <= grant_id;
            end
          end
        end
        LOCKED: begin
          if (xfer && xfer_tail) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRIZZLE_ALLOC_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the staged word is blocked by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stage_valid && out_FIFO_full && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0;
`endif

endmodule
